// File: rtl/test_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : test_pattern_gen
// Brief    : Registered four-mode display test-pattern generator (bars, grey
//            ramp, checker, bouncing box) with frame-synchronous mode/motion.
// Revision : 1.0 - initial release
// ============================================================================
module test_pattern_gen #(
    parameter int DISP_WIDTH  = 640,
    parameter int DISP_HEIGHT = 480,
    parameter int BAR_COLS    = 2,
    parameter int BAR_ROWS    = 4,
    parameter int GRAY_SHIFT  = 1,
    parameter int CHECK_LOG2  = 5,
    parameter int BOX_SIZE    = 64,
    parameter int MOVE_STEP   = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [11:0] disp_h_addr,
    input  logic [11:0] disp_v_addr,
    input  logic        disp_data_req,
    input  logic [1:0]  mode_i,
    input  logic        freeze_i,
    output logic [23:0] disp_data,
    output logic        disp_data_valid,
    output logic [15:0] frame_cnt
);

    typedef enum logic {DIR_INC = 1'b0, DIR_DEC = 1'b1} dir_t;

    localparam logic [11:0] C_W_LAST = 12'(DISP_WIDTH - 1);
    localparam logic [11:0] C_H_LAST = 12'(DISP_HEIGHT - 1);
    localparam logic [12:0] C_X_MAX  = 13'(DISP_WIDTH - BOX_SIZE);
    localparam logic [12:0] C_Y_MAX  = 13'(DISP_HEIGHT - BOX_SIZE);
    localparam logic [12:0] C_STEP   = 13'(MOVE_STEP);
    localparam logic [12:0] C_BOX    = 13'(BOX_SIZE);
    localparam logic [2:0]  C_COLS3  = 3'(BAR_COLS);
    localparam logic [23:0] C_WHITE  = 24'hFFFFFF;
    localparam logic [23:0] C_BLUE   = 24'h0000FF;

    logic [1:0]  r_mode;
    logic [12:0] r_box_x, r_box_y;
    dir_t        r_dir_x, r_dir_y;

    logic [12:0] w_box_x_nxt, w_box_y_nxt;
    dir_t        w_dir_x_nxt, w_dir_y_nxt;
    logic        w_frame_end;
    logic [7:1]  w_col_ge, w_row_ge;
    logic [2:0]  w_col, w_row, w_bar_idx;
    logic [11:0] w_gray_full;
    logic [7:0]  w_gray;
    logic        w_check, w_in_box, w_in_range;
    logic [23:0] w_pixel;

    // Palette index bits map straight onto the B, R and G channels.
    function automatic logic [23:0] palette(input logic [2:0] idx);
        return {{8{idx[1]}}, {8{idx[2]}}, {8{idx[0]}}};
    endfunction

    assign w_frame_end = disp_data_req && (disp_h_addr == C_W_LAST) && (disp_v_addr == C_H_LAST);

    // Bar boundaries are elaboration-time constants; a cell index is the number crossed.
    generate
        for (genvar gk = 1; gk < 8; gk++) begin : g_bound
            localparam logic [11:0] C_COL_B = 12'(gk * DISP_WIDTH / BAR_COLS);
            localparam logic [11:0] C_ROW_B = 12'(gk * DISP_HEIGHT / BAR_ROWS);
            assign w_col_ge[gk] = (gk < BAR_COLS) && (disp_h_addr >= C_COL_B);
            assign w_row_ge[gk] = (gk < BAR_ROWS) && (disp_v_addr >= C_ROW_B);
        end
    endgenerate

    always_comb begin
        w_col = 3'd0;
        w_row = 3'd0;
        for (int k = 1; k < 8; k++) begin
            w_col = w_col + 3'(w_col_ge[k]);
            w_row = w_row + 3'(w_row_ge[k]);
        end
        w_bar_idx = w_row * C_COLS3 + w_col;
    end

    assign w_gray_full = disp_h_addr >> GRAY_SHIFT;
    assign w_gray      = (|w_gray_full[11:8]) ? 8'hFF : w_gray_full[7:0];
    assign w_check     = disp_h_addr[CHECK_LOG2] ^ disp_v_addr[CHECK_LOG2];
    assign w_in_range  = (disp_h_addr < 12'(DISP_WIDTH)) && (disp_v_addr < 12'(DISP_HEIGHT));
    assign w_in_box    = ({1'b0, disp_h_addr} >= r_box_x) && ({1'b0, disp_h_addr} < r_box_x + C_BOX) &&
                         ({1'b0, disp_v_addr} >= r_box_y) && ({1'b0, disp_v_addr} < r_box_y + C_BOX);

    always_comb begin
        w_pixel = 24'h000000;
        if (disp_data_req && w_in_range) begin
            case (r_mode)
                2'd0:    w_pixel = palette(w_bar_idx);
                2'd1:    w_pixel = {w_gray, w_gray, w_gray};
                2'd2:    w_pixel = w_check ? C_WHITE : 24'h000000;
                default: w_pixel = w_in_box ? C_WHITE : C_BLUE;
            endcase
        end
    end

    // Box motion: clamp to the edge and reverse instead of overshooting.
    always_comb begin
        w_box_x_nxt = r_box_x;
        w_box_y_nxt = r_box_y;
        w_dir_x_nxt = r_dir_x;
        w_dir_y_nxt = r_dir_y;
        if (w_frame_end && !freeze_i) begin
            if (r_dir_x == DIR_INC) begin
                if (r_box_x + C_STEP >= C_X_MAX) begin
                    w_box_x_nxt = C_X_MAX;
                    w_dir_x_nxt = DIR_DEC;
                end else begin
                    w_box_x_nxt = r_box_x + C_STEP;
                end
            end else if (r_box_x <= C_STEP) begin
                w_box_x_nxt = 13'd0;
                w_dir_x_nxt = DIR_INC;
            end else begin
                w_box_x_nxt = r_box_x - C_STEP;
            end

            if (r_dir_y == DIR_INC) begin
                if (r_box_y + C_STEP >= C_Y_MAX) begin
                    w_box_y_nxt = C_Y_MAX;
                    w_dir_y_nxt = DIR_DEC;
                end else begin
                    w_box_y_nxt = r_box_y + C_STEP;
                end
            end else if (r_box_y <= C_STEP) begin
                w_box_y_nxt = 13'd0;
                w_dir_y_nxt = DIR_INC;
            end else begin
                w_box_y_nxt = r_box_y - C_STEP;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            disp_data       <= 24'h000000;
            disp_data_valid <= 1'b0;
            frame_cnt       <= 16'd0;
            r_mode          <= 2'd0;
            r_box_x         <= 13'd0;
            r_box_y         <= 13'd0;
            r_dir_x         <= DIR_INC;
            r_dir_y         <= DIR_INC;
        end else begin
            disp_data       <= w_pixel;
            disp_data_valid <= disp_data_req;
            if (w_frame_end) begin
                frame_cnt <= frame_cnt + 16'd1;
                r_mode    <= mode_i;
            end
            r_box_x <= w_box_x_nxt;
            r_box_y <= w_box_y_nxt;
            r_dir_x <= w_dir_x_nxt;
            r_dir_y <= w_dir_y_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_test_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_test_pattern_gen
// Brief    : Self-checking bench for test_pattern_gen (default and 8x1 bars).
// Revision : 1.0 - initial release
// ============================================================================
module tb_test_pattern_gen;

    localparam int W    = 640;
    localparam int H    = 480;
    localparam int BOX  = 64;
    localparam int STEP = 4;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [11:0] h = '0, v = '0;
    logic        req = 1'b0;
    logic [1:0]  mode_i = 2'd0;
    logic        freeze_i = 1'b0;
    logic [23:0] data_a, data_b;
    logic        valid_a, valid_b;
    logic [15:0] fc_a, fc_b;

    always #5 Clk = ~Clk;

    test_pattern_gen u_dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .disp_h_addr(h), .disp_v_addr(v),
        .disp_data_req(req), .mode_i(mode_i), .freeze_i(freeze_i),
        .disp_data(data_a), .disp_data_valid(valid_a), .frame_cnt(fc_a)
    );

    test_pattern_gen #(.BAR_COLS(8), .BAR_ROWS(1)) u_dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .disp_h_addr(h), .disp_v_addr(v),
        .disp_data_req(req), .mode_i(mode_i), .freeze_i(freeze_i),
        .disp_data(data_b), .disp_data_valid(valid_b), .frame_cnt(fc_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: active mode, number of box moves, completed frames.
    int m_mode, m_moves, m_frames;

    logic [23:0] pal [0:7] = '{24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
                               24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF};

    // Box position as a triangle wave of the move count.
    function automatic int tri_pos(int moves, int span);
        int n, k, p;
        n = (span + STEP - 1) / STEP;
        k = moves % (2 * n);
        if (k <= n) begin
            p = k * STEP;
            return (p > span) ? span : p;
        end
        p = span - (k - n) * STEP;
        return (p < 0) ? 0 : p;
    endfunction

    function automatic logic [23:0] expect_px(int hh, int vv, bit rq, int cols, int rows);
        int col, row, g, bx, by;
        logic [7:0] g8;
        if (!rq || hh >= W || vv >= H) return 24'h000000;
        case (m_mode)
            0: begin
                col = 0;
                row = 0;
                for (int k = 0; k < cols; k++) if (hh >= k * W / cols) col = k;
                for (int k = 0; k < rows; k++) if (vv >= k * H / rows) row = k;
                return pal[(row * cols + col) % 8];
            end
            1: begin
                g = hh >> 1;
                if (g > 255) g = 255;
                g8 = 8'(g);
                return {g8, g8, g8};
            end
            2: return ((((hh >> 5) ^ (vv >> 5)) & 1) == 1) ? 24'hFFFFFF : 24'h000000;
            default: begin
                bx = tri_pos(m_moves, W - BOX);
                by = tri_pos(m_moves, H - BOX);
                return (hh >= bx && hh < bx + BOX && vv >= by && vv < by + BOX) ? 24'hFFFFFF : 24'h0000FF;
            end
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_moves = 0;
        m_frames = 0;
    endtask

    // One request cycle; outputs are settled #1 after the capturing edge.
    task automatic drive(int hh, int vv, bit rq);
        @(negedge Clk);
        h = 12'(hh);
        v = 12'(vv);
        req = rq;
        @(posedge Clk);
        #1;
        if (rq && hh == W - 1 && vv == H - 1) begin
            m_frames++;
            m_mode = int'(mode_i);
            if (!freeze_i) m_moves++;
        end
    endtask

    task automatic do_reset();
        req = 1'b0;
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        req = 1'b0;
        mode_i = 2'd0;
        freeze_i = 1'b0;
        Reset_n = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        n_vec++;
        if ({data_a, valid_a, fc_a} !== 41'd0) begin
            n_err++;
            $display("FAIL reset_hold: got data=%h valid=%b fc=%0d, want 0/0/0", data_a, valid_a, fc_a);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
        @(posedge Clk);
        #1;
        n_vec++;
        if ({data_a, valid_a, fc_a} !== 41'd0 || {data_b, valid_b, fc_b} !== 41'd0) begin
            n_err++;
            $display("FAIL reset_idle: got a=%h/%b/%0d b=%h/%b/%0d, want all 0",
                     data_a, valid_a, fc_a, data_b, valid_b, fc_b);
        end
    endtask

    task automatic test_default_bars();
        int          th [4] = '{0, 320, 0, 639};
        int          tv [4] = '{0, 0, 120, 479};
        logic [23:0] te [4] = '{24'h000000, 24'h0000FF, 24'hFF0000, 24'hFFFFFF};
        for (int i = 0; i < 4; i++) begin
            drive(th[i], tv[i], 1'b1);
            n_vec++;
            if (data_a !== te[i] || valid_a !== 1'b1) begin
                n_err++;
                $display("FAIL default_bars(%0d,%0d): got %h valid=%b, want %h valid=1",
                         th[i], tv[i], data_a, valid_a, te[i]);
            end
        end
        drive(5, 5, 1'b0);
        n_vec++;
        if (data_a !== 24'h0 || valid_a !== 1'b0) begin
            n_err++;
            $display("FAIL request_low: got %h valid=%b, want 000000 valid=0", data_a, valid_a);
        end
    endtask

    task automatic test_param_bars();
        int          th [3] = '{79, 80, 560};
        logic [23:0] te [3] = '{24'h000000, 24'h0000FF, 24'hFFFFFF};
        for (int i = 0; i < 3; i++) begin
            drive(th[i], 0, 1'b1);
            n_vec++;
            if (data_b !== te[i]) begin
                n_err++;
                $display("FAIL param_bars(h=%0d): got %h, want %h", th[i], data_b, te[i]);
            end
        end
    endtask

    task automatic test_mode_switch();
        int          lines [6] = '{0, 50, 99, 100, 130, 479};
        logic [23:0] exp_a;
        do_reset();
        mode_i = 2'd0;
        for (int i = 0; i < 6; i++) begin
            if (lines[i] == 100) mode_i = 2'd2;
            exp_a = expect_px(320, lines[i], 1'b1, 2, 4);
            drive(320, lines[i], 1'b1);
            n_vec++;
            if (data_a !== exp_a) begin
                n_err++;
                $display("FAIL frame0_bars(v=%0d): got %h, want %h", lines[i], data_a, exp_a);
            end
        end
        drive(W - 1, H - 1, 1'b1);
        n_vec++;
        if (data_a !== 24'hFFFFFF) begin
            n_err++;
            $display("FAIL frame_end_old_mode: got %h, want FFFFFF", data_a);
        end
        mode_i = 2'd3;
        drive(32, 0, 1'b1);
        n_vec++;
        if (data_a !== 24'hFFFFFF || fc_a !== 16'd1) begin
            n_err++;
            $display("FAIL checker(32,0): got %h fc=%0d, want FFFFFF fc=1", data_a, fc_a);
        end
        drive(32, 32, 1'b1);
        n_vec++;
        if (data_a !== 24'h000000) begin
            n_err++;
            $display("FAIL checker(32,32): got %h, want 000000", data_a);
        end
    endtask

    task automatic test_box_bounce();
        int          ph [4];
        int          pv [4];
        logic [23:0] pe [4];
        logic [23:0] exp_a;
        do_reset();
        mode_i = 2'd3;
        freeze_i = 1'b0;
        for (int f = 1; f <= 144; f++) begin
            exp_a = expect_px(W - 1, H - 1, 1'b1, 2, 4);
            drive(W - 1, H - 1, 1'b1);
            n_vec++;
            if (data_a !== exp_a) begin
                n_err++;
                $display("FAIL box_frame_end(f=%0d): got %h, want %h", f, data_a, exp_a);
            end
        end
        // After 144 moves the box sits at (576,256).
        ph = '{575, 576, 639, 576};
        pv = '{256, 256, 256, 255};
        pe = '{24'h0000FF, 24'hFFFFFF, 24'hFFFFFF, 24'h0000FF};
        for (int i = 0; i < 4; i++) begin
            drive(ph[i], pv[i], 1'b1);
            n_vec++;
            if (data_a !== pe[i]) begin
                n_err++;
                $display("FAIL box_144(%0d,%0d): got %h, want %h", ph[i], pv[i], data_a, pe[i]);
            end
        end
        drive(W - 1, H - 1, 1'b1);
        // One more move: (572,252), now heading left and up.
        ph = '{571, 572, 635, 636};
        pv = '{252, 252, 252, 252};
        pe = '{24'h0000FF, 24'hFFFFFF, 24'hFFFFFF, 24'h0000FF};
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                drive(ph[i], pv[i], 1'b1);
                n_vec++;
                if (data_a !== pe[i]) begin
                    n_err++;
                    $display("FAIL box_145_pass%0d(%0d,%0d): got %h, want %h", r, ph[i], pv[i], data_a, pe[i]);
                end
            end
            freeze_i = 1'b1;
            drive(W - 1, H - 1, 1'b1);
            drive(W - 1, H - 1, 1'b1);
        end
        freeze_i = 1'b0;
    endtask

    task automatic test_random();
        int          hh, vv;
        bit          rq;
        logic [23:0] exp_a, exp_b;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                hh = W - 1;
                vv = H - 1;
                rq = 1'b1;
                mode_i = 2'($urandom_range(0, 3));
                freeze_i = ($urandom_range(0, 3) == 0);
            end else begin
                hh = $urandom_range(0, W + 20);
                vv = $urandom_range(0, H + 10);
                rq = ($urandom_range(0, 6) != 0);
            end
            exp_a = expect_px(hh, vv, rq, 2, 4);
            exp_b = expect_px(hh, vv, rq, 8, 1);
            drive(hh, vv, rq);
            n_vec++;
            if (data_a !== exp_a || data_b !== exp_b || valid_a !== rq || fc_a !== 16'(m_frames)) begin
                n_err++;
                $display("FAIL random(%0d,%0d,req=%0d,mode=%0d): got a=%h b=%h v=%b fc=%0d, want a=%h b=%h v=%0d fc=%0d",
                         hh, vv, rq, m_mode, data_a, data_b, valid_a, fc_a, exp_a, exp_b, rq, m_frames);
            end
        end
        freeze_i = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int          ph [3] = '{3, 4, 4};
        int          pv [3] = '{4, 4, 3};
        logic [23:0] pe [3] = '{24'h0000FF, 24'hFFFFFF, 24'h0000FF};
        logic [23:0] exp_a;
        do_reset();
        mode_i = 2'd3;
        for (int f = 0; f < 20; f++) drive(W - 1, H - 1, 1'b1);
        exp_a = expect_px(200, 200, 1'b1, 2, 4);
        drive(200, 200, 1'b1);
        n_vec++;
        if (data_a !== exp_a || valid_a !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset(200,200): got %h valid=%b, want %h valid=1", data_a, valid_a, exp_a);
        end
        #2;
        Reset_n = 1'b0;
        #1;
        n_vec++;
        if ({data_a, valid_a, fc_a} !== 41'd0) begin
            n_err++;
            $display("FAIL async_reset: got data=%h valid=%b fc=%0d, want 0/0/0", data_a, valid_a, fc_a);
        end
        req = 1'b0;
        mode_i = 2'd3;
        @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
        drive(320, 0, 1'b1);
        n_vec++;
        if (data_a !== 24'h0000FF) begin
            n_err++;
            $display("FAIL post_reset_bars: got %h, want 0000FF", data_a);
        end
        drive(W - 1, H - 1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(ph[i], pv[i], 1'b1);
            n_vec++;
            if (data_a !== pe[i]) begin
                n_err++;
                $display("FAIL box_from_origin(%0d,%0d): got %h, want %h", ph[i], pv[i], data_a, pe[i]);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default_bars();
        test_param_bars();
        test_mode_switch();
        test_box_bounce();
        test_random();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
